// File: rtl/ex_stage_core.sv
// ex_stage_core: execute stage latching ID/EX operands on the falling edge and driving ALU result, flags and branch condition.
module ex_instr_analyser (
   input  logic [31:0] ir,
   output logic        is_alur,
   output logic        is_branch
);
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       funct_ok;
   assign opcode = ir[31:26];
   assign funct  = ir[5:0];
   always_comb begin
      funct_ok = 1'b0;
      case (funct)
         6'b100000, 6'b100010, 6'b100100, 6'b100101,
         6'b100110, 6'b100111, 6'b101010, 6'b000100: funct_ok = 1'b1;
         default: funct_ok = 1'b0;
      endcase
   end
   assign is_alur   = (opcode == 6'b000000) && funct_ok;
   assign is_branch = opcode == 6'b000100;
endmodule

module ex_alu_op_ctrl (
   input  logic [31:0] ir,
   output logic [2:0]  alu_op
);
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_NOR = 3'b011;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;
   localparam logic [2:0] OP_SLT = 3'b110;
   localparam logic [2:0] OP_SLL = 3'b111;
   always_comb begin
      alu_op = OP_ADD;
      if (ir[31:26] == 6'b000000) begin
         case (ir[5:0])
            6'b100000: alu_op = OP_ADD;
            6'b100010: alu_op = OP_SUB;
            6'b100100: alu_op = OP_AND;
            6'b100101: alu_op = OP_OR;
            6'b100110: alu_op = OP_XOR;
            6'b100111: alu_op = OP_NOR;
            6'b101010: alu_op = OP_SLT;
            6'b000100: alu_op = OP_SLL;
            default:   alu_op = OP_ADD;
         endcase
      end else begin
         case (ir[31:26])
            6'b001100: alu_op = OP_AND;
            6'b001101: alu_op = OP_OR;
            6'b001110: alu_op = OP_XOR;
            6'b001010: alu_op = OP_SLT;
            default:   alu_op = OP_ADD;
         endcase
      end
   end
endmodule

module ex_alu (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  op,
   output logic [31:0] f,
   output logic        of
);
   logic [31:0] sum;
   logic [31:0] diff;
   assign sum  = a + b;
   assign diff = a - b;
   always_comb begin
      f = sum;
      case (op)
         3'b000: f = a & b;
         3'b001: f = a | b;
         3'b010: f = a ^ b;
         3'b011: f = ~(a | b);
         3'b100: f = sum;
         3'b101: f = diff;
         3'b110: f = {31'b0, $signed(a) < $signed(b)};
         3'b111: f = b << a[4:0];
         default: f = sum;
      endcase
   end
   // Overflow: result sign disagrees with A where the operand signs make that impossible
   assign of = (op == 3'b100) ? (a[31] == b[31]) && (sum[31] != a[31]) :
               (op == 3'b101) ? (a[31] != b[31]) && (diff[31] != a[31]) : 1'b0;
endmodule

module ex_stage_core (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] IRi,
   input  logic [31:0] NPCi,
   input  logic [31:0] Ai,
   input  logic [31:0] Bi,
   input  logic [31:0] Immi,
   output logic        cond,
   output logic [31:0] ALUo,
   output logic        ZFo,
   output logic        OFo,
   output logic [31:0] Bo,
   output logic [31:0] IRo
);
   logic        is_alur;
   logic        is_branch;
   logic [31:0] ir_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [2:0]  alu_op;
   ex_instr_analyser u_ana (.ir(IRi), .is_alur(is_alur), .is_branch(is_branch));
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         ir_q <= 32'hFFFF_FFFF;
         a_q  <= 32'h0;
         b_q  <= 32'h0;
      end else begin
         ir_q <= IRi;
         a_q  <= is_branch ? NPCi : Ai;
         b_q  <= is_alur ? Bi : is_branch ? Immi << 2 : Immi;
      end
   end
   ex_alu_op_ctrl u_ctrl (.ir(ir_q), .alu_op(alu_op));
   ex_alu u_alu (.a(a_q), .b(b_q), .op(alu_op), .f(ALUo), .of(OFo));
   assign ZFo  = ALUo == 32'h0;
   assign cond = a_q == 32'h0;
   assign Bo   = b_q;
   assign IRo  = ir_q;
endmodule

// File: tb/tb_ex_stage_core.sv
// tb_ex_stage_core: directed and randomized checks of ex_stage_core against an arithmetic reference model.
module tb_ex_stage_core;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] IRi, NPCi, Ai, Bi, Immi;
   logic        cond, ZFo, OFo;
   logic [31:0] ALUo, Bo, IRo;
   int          checks = 0;
   int          errors = 0;
   ex_stage_core dut (
      .clk(clk), .rst(rst), .IRi(IRi), .NPCi(NPCi), .Ai(Ai), .Bi(Bi), .Immi(Immi),
      .cond(cond), .ALUo(ALUo), .ZFo(ZFo), .OFo(OFo), .Bo(Bo), .IRo(IRo)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   typedef enum {M_AND, M_OR, M_XOR, M_NOR, M_ADD, M_SUB, M_SLT, M_SLL} mop_t;
   function automatic mop_t op_for(input logic [31:0] ir);
      logic [5:0] oc = ir[31:26];
      logic [5:0] fn = ir[5:0];
      if (oc == 6'd0) begin
         if (fn == 6'b100010) return M_SUB;
         if (fn == 6'b100100) return M_AND;
         if (fn == 6'b100101) return M_OR;
         if (fn == 6'b100110) return M_XOR;
         if (fn == 6'b100111) return M_NOR;
         if (fn == 6'b101010) return M_SLT;
         if (fn == 6'b000100) return M_SLL;
         return M_ADD;
      end
      if (oc == 6'b001100) return M_AND;
      if (oc == 6'b001101) return M_OR;
      if (oc == 6'b001110) return M_XOR;
      if (oc == 6'b001010) return M_SLT;
      return M_ADD;
   endfunction
   // Expected outputs after one capture of the given inputs
   task automatic expect_all(input string tag, input logic [31:0] ir, npc, a, b, imm);
      logic [5:0] oc = ir[31:26];
      logic [5:0] fn = ir[5:0];
      bit alur = (oc == 6'd0) && (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                              6'b100110, 6'b100111, 6'b101010, 6'b000100});
      bit br = (oc == 6'b000100);
      logic [31:0] la = br ? npc : a;
      logic [31:0] lb = alur ? b : br ? imm * 4 : imm;
      longint sa = longint'($signed(la));
      longint sb = longint'($signed(lb));
      longint r = 0;
      logic [31:0] f;
      bit of = 0;
      case (op_for(ir))
         M_AND: f = la & lb;
         M_OR:  f = la | lb;
         M_XOR: f = la ^ lb;
         M_NOR: f = ~(la | lb);
         M_SUB: begin r = sa - sb; f = r[31:0]; of = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
         M_SLT: f = (sa < sb) ? 32'd1 : 32'd0;
         M_SLL: f = lb << la[4:0];
         default: begin r = sa + sb; f = r[31:0]; of = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      endcase
      chk({tag, ".IRo"}, IRo, ir);
      chk({tag, ".Bo"}, Bo, lb);
      chk({tag, ".ALUo"}, ALUo, f);
      chk({tag, ".ZFo"}, {31'b0, ZFo}, {31'b0, f == 32'd0});
      chk({tag, ".OFo"}, {31'b0, OFo}, {31'b0, of});
      chk({tag, ".cond"}, {31'b0, cond}, {31'b0, la == 32'd0});
   endtask
   task automatic apply(input string tag, input logic [31:0] ir, npc, a, b, imm);
      @(posedge clk);
      #1;
      IRi = ir; NPCi = npc; Ai = a; Bi = b; Immi = imm;
      @(negedge clk);
      #1;
      expect_all(tag, ir, npc, a, b, imm);
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, ".IRo"}, IRo, 32'hFFFF_FFFF);
      chk({tag, ".Bo"}, Bo, 32'h0);
      chk({tag, ".ALUo"}, ALUo, 32'h0);
      chk({tag, ".ZFo"}, {31'b0, ZFo}, 32'd1);
      chk({tag, ".OFo"}, {31'b0, OFo}, 32'd0);
      chk({tag, ".cond"}, {31'b0, cond}, 32'd1);
   endtask
   function automatic logic [31:0] rand_word();
      logic [31:0] picks [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_001F};
      return ($urandom_range(3) == 0) ? picks[$urandom_range(5)] : $urandom;
   endfunction
   function automatic logic [31:0] rand_ir();
      logic [5:0] fns [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b000100};
      logic [5:0] ops [8] = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b100011, 6'b101011, 6'b000100};
      logic [31:0] w = $urandom;
      case ($urandom_range(3))
         0: return {6'b0, w[25:6], fns[$urandom_range(7)]};
         1: return {ops[$urandom_range(7)], w[25:0]};
         2: return ($urandom_range(1) == 0) ? 32'hFFFF_FFFF : {6'b0, w[25:0]};
         default: return w;
      endcase
   endfunction
   initial begin
      rst = 1'b1;
      IRi = 32'h0; NPCi = 32'h0; Ai = 32'h0; Bi = 32'h0; Immi = 32'h0;
      #2 rst = 1'b0;
      #1 chk_reset("reset_async");
      @(negedge clk);
      #1 chk_reset("reset_hold");
      @(posedge clk);
      #1 rst = 1'b1;
      apply("radd", 32'h0000_0020, 32'h0, 32'd5, 32'd7, 32'h0);
      chk("radd.const", ALUo, 32'd12);
      apply("sub_of", 32'h0000_0022, 32'h0, 32'h8000_0000, 32'd1, 32'h0);
      chk("sub_of.const", {31'b0, OFo}, 32'd1);
      apply("addi_zero", 32'h2000_0000, 32'h0, 32'd1, 32'h0, 32'hFFFF_FFFF);
      chk("addi_zero.zf", {31'b0, ZFo}, 32'd1);
      apply("branch", 32'h1000_0000, 32'h100, 32'h0, 32'h0, 32'd4);
      chk("branch.const", ALUo, 32'h110);
      apply("branch_npc0", 32'h1000_0000, 32'h0, 32'h5, 32'h0, 32'd4);
      chk("branch_npc0.cond", {31'b0, cond}, 32'd1);
      apply("slt", 32'h0000_002A, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0);
      chk("slt.const", ALUo, 32'd1);
      apply("bubble", 32'hFFFF_FFFF, 32'h0, 32'd3, 32'h0, 32'd2);
      chk("bubble.const", ALUo, 32'd5);
      apply("sll", 32'h0000_0004, 32'h0, 32'd35, 32'h0000_0003, 32'h0);
      chk("sll.const", ALUo, 32'h0000_0018);
      apply("add_of", 32'h0000_0020, 32'h0, 32'h7FFF_FFFF, 32'd1, 32'h0);
      chk("add_of.const", {31'b0, OFo}, 32'd1);
      for (int i = 0; i < 300; i++) begin
         apply($sformatf("rnd%0d", i), rand_ir(), rand_word(), rand_word(), rand_word(), rand_word());
         if (i == 150) begin
            @(posedge clk);
            #2 rst = 1'b0;
            #1 chk_reset("reset_mid");
            @(posedge clk);
            #1 rst = 1'b1;
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
